// File: rtl/sdram_play_fetcher.sv
// Playback fetcher: streams a run of samples from the SDRAM play port into a small FIFO
// and returns one sample per DAC request, counting requests that find the FIFO empty.
module sdram_play_fetcher #(
    parameter int unsigned ADDR_W     = 23,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned UCNT_W     = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic [ADDR_W-1:0] i_start_addr,
    input  logic [ADDR_W-1:0] i_length,
    input  logic              i_sample_req,
    output logic [DATA_W-1:0] o_sample,
    output logic              o_sample_valid,
    output logic              o_busy,
    output logic              o_done,
    output logic [UCNT_W-1:0] o_underrun_cnt,
    output logic              play_read,
    output logic [ADDR_W-1:0] play_addr,
    input  logic [DATA_W-1:0] play_readdata,
    input  logic              play_read_finished
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic              stop_pend_q, stop_pend_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              read_q, read_d;
    logic [UCNT_W-1:0] ucnt_q, ucnt_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic              valid_q, valid_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

    logic push;
    logic pop;
    logic flush;
    logic clr_ucnt;

    // Next-state, FIFO control and sample path
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        stop_pend_d = stop_pend_q;
        done_d      = 1'b0;
        push        = 1'b0;
        flush       = 1'b0;
        clr_ucnt    = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_start && !i_stop) begin
                    addr_d   = i_start_addr;
                    rem_d    = i_length;
                    clr_ucnt = 1'b1;
                    if (i_length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (i_stop) begin
                    flush   = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q < CNT_W'(FIFO_DEPTH)) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A bus read is always completed; a pending stop only discards its data
                if (i_stop) begin
                    stop_pend_d = 1'b1;
                end
                if (play_read_finished) begin
                    if (stop_pend_q || i_stop) begin
                        flush       = 1'b1;
                        stop_pend_d = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        push    = 1'b1;
                        addr_d  = addr_q + ADDR_W'(1);
                        rem_d   = rem_q - ADDR_W'(1);
                        state_d = (rem_q == ADDR_W'(1)) ? DRAIN : ISSUE;
                    end
                end
            end
            DRAIN: begin
                if (i_stop) begin
                    flush   = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        read_d = (state_d == WAIT);

        pop      = i_sample_req && (cnt_q != '0);
        valid_d  = i_sample_req;
        sample_d = pop ? mem_q[rd_ptr_q] : '0;

        ucnt_d = ucnt_q;
        if (clr_ucnt) begin
            ucnt_d = '0;
        end else if (i_sample_req && (cnt_q == '0) && busy_q && (ucnt_q != {UCNT_W{1'b1}})) begin
            ucnt_d = ucnt_q + UCNT_W'(1);
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            stop_pend_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            read_q      <= 1'b0;
            ucnt_q      <= '0;
            sample_q    <= '0;
            valid_q     <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            stop_pend_q <= stop_pend_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            read_q      <= read_d;
            ucnt_q      <= ucnt_d;
            sample_q    <= sample_d;
            valid_q     <= valid_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    // Sample storage needs no reset; occupancy is tracked by cnt_q
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= play_readdata;
        end
    end

    assign o_sample       = sample_q;
    assign o_sample_valid = valid_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_underrun_cnt = ucnt_q;
    assign play_read      = read_q;
    assign play_addr      = addr_q;

endmodule

// File: tb/tb_sdram_play_fetcher.sv
// Directed bench for sdram_play_fetcher with a fixed-latency SDRAM play-port responder.
module tb_sdram_play_fetcher;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_start;
    logic        i_stop;
    logic [22:0] i_start_addr;
    logic [22:0] i_length;
    logic        i_sample_req;
    logic [15:0] o_sample;
    logic        o_sample_valid;
    logic        o_busy;
    logic        o_done;
    logic [7:0]  o_underrun_cnt;
    logic        play_read;
    logic [22:0] play_addr;
    logic [15:0] play_readdata;
    logic        play_read_finished;

    int checks;
    int failures;
    int lat;
    int rd_count;
    int rd_base;
    int done_cnt;
    int nz_cnt;
    logic [22:0] addr_log [64];

    sdram_play_fetcher dut (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_start            (i_start),
        .i_stop             (i_stop),
        .i_start_addr       (i_start_addr),
        .i_length           (i_length),
        .i_sample_req       (i_sample_req),
        .o_sample           (o_sample),
        .o_sample_valid     (o_sample_valid),
        .o_busy             (o_busy),
        .o_done             (o_done),
        .o_underrun_cnt     (o_underrun_cnt),
        .play_read          (play_read),
        .play_addr          (play_addr),
        .play_readdata      (play_readdata),
        .play_read_finished (play_read_finished)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // SDRAM responder: finished asserted lat cycles after play_read rises, data = A0 + read index
    initial begin
        rd_count           = 0;
        play_read_finished = 1'b0;
        play_readdata      = '0;
        forever begin
            @(negedge i_clk);
            if (play_read && i_rst_n) begin
                if (rd_count - rd_base < 64) addr_log[rd_count - rd_base] = play_addr;
                repeat (lat - 1) @(negedge i_clk);
                play_readdata      = 16'h00A0 + 16'(rd_count - rd_base);
                play_read_finished = 1'b1;
                rd_count++;
                @(negedge i_clk);
                play_read_finished = 1'b0;
            end
        end
    end

    initial begin
        done_cnt = 0;
        nz_cnt   = 0;
        forever begin
            @(posedge i_clk);
            #1;
            if (o_done) done_cnt++;
            if (o_sample_valid && o_sample != 16'h0) nz_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic do_start(input logic [22:0] a, input logic [22:0] l);
        i_start_addr = a;
        i_length     = l;
        i_start      = 1'b1;
        tick(1);
        i_start      = 1'b0;
    endtask

    task automatic req(output logic [15:0] s, output logic v);
        i_sample_req = 1'b1;
        tick(1);
        s = o_sample;
        v = o_sample_valid;
        i_sample_req = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            i_start      = 1'($urandom);
            i_stop       = 1'($urandom);
            i_sample_req = 1'($urandom);
            i_start_addr = 23'($urandom);
            i_length     = 23'($urandom);
            tick(1);
            checks++;
            if ({o_sample, o_sample_valid, o_busy, o_done, o_underrun_cnt, play_read, play_addr} !== '0) begin
                failures++;
                $display("FAIL reset_outputs: busy=%b done=%b valid=%b sample=%h ucnt=%0d read=%b addr=%h, required all 0",
                         o_busy, o_done, o_sample_valid, o_sample, o_underrun_cnt, play_read, play_addr);
            end
        end
        i_start = 1'b0; i_stop = 1'b0; i_sample_req = 1'b0;
        i_rst_n = 1'b1;
        tick(3);
        checks++;
        if (play_read !== 1'b0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: play_read=%b busy=%b, required 0 0", play_read, o_busy);
        end
    endtask

    task automatic test_basic();
        logic [15:0] s;
        logic        v;
        int          n;
        int          d0;
        lat = 3; rd_base = rd_count; d0 = done_cnt;
        do_start(23'h100, 23'd4);
        checks++;
        if (o_busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy: busy=%b, required 1", o_busy);
        end
        n = 0;
        while (rd_count - rd_base < 4 && n < 100) begin tick(1); n++; end
        checks++;
        if (n >= 100) begin
            failures++;
            $display("FAIL basic_reads_timeout: reads=%0d, required 4", rd_count - rd_base);
        end
        tick(3);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (addr_log[i] !== 23'h100 + 23'(i)) begin
                failures++;
                $display("FAIL basic_addr[%0d]: got %h, required %h", i, addr_log[i], 23'h100 + 23'(i));
            end
        end
        for (int i = 0; i < 4; i++) begin
            req(s, v);
            checks++;
            if (v !== 1'b1 || s !== 16'h00A0 + 16'(i)) begin
                failures++;
                $display("FAIL basic_sample[%0d]: valid=%b sample=%h, required 1 %h", i, v, s, 16'h00A0 + 16'(i));
            end
        end
        tick(3);
        checks++;
        if (done_cnt - d0 != 1 || o_busy !== 1'b0 || o_underrun_cnt !== 8'd0) begin
            failures++;
            $display("FAIL basic_done: done_pulses=%0d busy=%b ucnt=%0d, required 1 0 0", done_cnt - d0, o_busy, o_underrun_cnt);
        end
    endtask

    task automatic test_fill();
        logic [15:0] s;
        logic        v;
        int          d0;
        lat = 3; rd_base = rd_count; d0 = done_cnt;
        do_start(23'h200, 23'd20);
        tick(100);
        checks++;
        if (rd_count - rd_base != 8 || play_read !== 1'b0) begin
            failures++;
            $display("FAIL fill_stall: reads=%0d play_read=%b, required 8 0", rd_count - rd_base, play_read);
        end
        req(s, v);
        checks++;
        if (v !== 1'b1 || s !== 16'h00A0) begin
            failures++;
            $display("FAIL fill_pop: valid=%b sample=%h, required 1 00a0", v, s);
        end
        tick(30);
        checks++;
        if (rd_count - rd_base != 9 || play_read !== 1'b0) begin
            failures++;
            $display("FAIL fill_refill: reads=%0d play_read=%b, required 9 0", rd_count - rd_base, play_read);
        end
        i_stop = 1'b1;
        tick(1);
        i_stop = 1'b0;
        req(s, v);
        checks++;
        if (o_busy !== 1'b0 || v !== 1'b1 || s !== 16'h0 || done_cnt != d0) begin
            failures++;
            $display("FAIL fill_stop_flush: busy=%b valid=%b sample=%h done_pulses=%0d, required 0 1 0000 0",
                     o_busy, v, s, done_cnt - d0);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] s;
        logic        v;
        logic [22:0] exp_a [3];
        int          n;
        int          d0;
        exp_a[0] = 23'h7FFFFE; exp_a[1] = 23'h7FFFFF; exp_a[2] = 23'h000000;
        lat = 3; rd_base = rd_count; d0 = done_cnt;
        do_start(23'h7FFFFE, 23'd3);
        n = 0;
        while (rd_count - rd_base < 3 && n < 100) begin tick(1); n++; end
        tick(3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (addr_log[i] !== exp_a[i]) begin
                failures++;
                $display("FAIL wrap_addr[%0d]: got %h, required %h", i, addr_log[i], exp_a[i]);
            end
        end
        for (int i = 0; i < 3; i++) req(s, v);
        tick(3);
        checks++;
        if (done_cnt - d0 != 1 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL wrap_done: done_pulses=%0d busy=%b, required 1 0", done_cnt - d0, o_busy);
        end
    endtask

    task automatic test_underrun();
        int n;
        int d0;
        int z0;
        lat = 10; rd_base = rd_count; d0 = done_cnt; z0 = nz_cnt;
        i_sample_req = 1'b1;
        do_start(23'h400, 23'd1);
        n = 0;
        while (o_busy && n < 200) begin tick(1); n++; end
        checks++;
        if (o_underrun_cnt !== 8'd12 || nz_cnt - z0 != 1 || done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL underrun_single: ucnt=%0d data_samples=%0d done_pulses=%0d, required 12 1 1",
                     o_underrun_cnt, nz_cnt - z0, done_cnt - d0);
        end
        tick(10);
        checks++;
        if (o_underrun_cnt !== 8'd12) begin
            failures++;
            $display("FAIL underrun_idle_hold: ucnt=%0d, required 12", o_underrun_cnt);
        end
        rd_base = rd_count; z0 = nz_cnt;
        do_start(23'h500, 23'd30);
        checks++;
        if (o_underrun_cnt !== 8'd0) begin
            failures++;
            $display("FAIL underrun_clear_on_start: ucnt=%0d, required 0", o_underrun_cnt);
        end
        n = 0;
        while (o_busy && n < 2000) begin tick(1); n++; end
        tick(5);
        checks++;
        if (o_underrun_cnt !== 8'd255 || nz_cnt - z0 != 30 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL underrun_saturate: ucnt=%0d data_samples=%0d busy=%b, required 255 30 0",
                     o_underrun_cnt, nz_cnt - z0, o_busy);
        end
        i_sample_req = 1'b0;
        tick(2);
    endtask

    task automatic test_stop();
        logic [15:0] s;
        logic        v;
        int          n;
        int          d0;
        int          z0;
        lat = 10; rd_base = rd_count; d0 = done_cnt; z0 = nz_cnt;
        do_start(23'h300, 23'd4);
        n = 0;
        while (!play_read && n < 10) begin tick(1); n++; end
        tick(2);
        i_stop = 1'b1;
        tick(1);
        i_stop = 1'b0;
        checks++;
        if (play_read !== 1'b1 || play_addr !== 23'h300) begin
            failures++;
            $display("FAIL stop_hold_read: play_read=%b addr=%h, required 1 300", play_read, play_addr);
        end
        n = 0;
        while (play_read && n < 30) begin tick(1); n++; end
        checks++;
        if (n >= 30 || o_busy !== 1'b0 || rd_count - rd_base != 1) begin
            failures++;
            $display("FAIL stop_complete: wait=%0d busy=%b reads=%0d, required <30 0 1", n, o_busy, rd_count - rd_base);
        end
        tick(5);
        req(s, v);
        checks++;
        if (play_read !== 1'b0 || v !== 1'b1 || s !== 16'h0 || nz_cnt != z0 || done_cnt != d0 || o_underrun_cnt !== 8'd0) begin
            failures++;
            $display("FAIL stop_discard: read=%b valid=%b sample=%h data_samples=%0d done_pulses=%0d ucnt=%0d, required 0 1 0000 0 0 0",
                     play_read, v, s, nz_cnt - z0, done_cnt - d0, o_underrun_cnt);
        end
        rd_base = rd_count;
        i_start_addr = 23'h600; i_length = 23'd4;
        i_start = 1'b1; i_stop = 1'b1;
        tick(1);
        i_start = 1'b0; i_stop = 1'b0;
        tick(10);
        checks++;
        if (rd_count != rd_base || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL start_stop_same: reads=%0d busy=%b, required 0 0", rd_count - rd_base, o_busy);
        end
        d0 = done_cnt;
        do_start(23'h700, 23'd0);
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b1) begin
            failures++;
            $display("FAIL len0_pulse: busy=%b done=%b, required 0 1", o_busy, o_done);
        end
        tick(5);
        checks++;
        if (done_cnt - d0 != 1 || rd_count != rd_base || play_read !== 1'b0) begin
            failures++;
            $display("FAIL len0_only_done: done_pulses=%0d reads=%0d play_read=%b, required 1 0 0",
                     done_cnt - d0, rd_count - rd_base, play_read);
        end
    endtask

    initial begin
        checks = 0; failures = 0; lat = 3; rd_base = 0;
        i_rst_n = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_sample_req = 1'b0;
        i_start_addr = '0; i_length = '0;
        tick(1);
        test_reset();
        test_basic();
        test_fill();
        test_wrap();
        test_underrun();
        test_stop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
